// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: one-beat pipeline stage register with valid/ready handshake,
// synchronous flush and a saturating stall-cycle counter.
// Build option: define SKID_BUFFER_EN to add a skid register so that in_ready
// comes straight from a flop; without it the stage is a single register with
// a combinational in_ready.
//
// Handshake: a beat crosses a side at posedge when that side's valid && ready
// are both 1. in_valid must not depend on in_ready. Priority is
// rst > flush > transfer; flush empties the stage, discards any beat accepted
// in the same cycle and leaves out_data untouched.
//
// fsm_state reports occupancy for debug: 0 = empty, 1 = one beat, 2 = two
// beats (skid build only).
module pipe_stage_hs #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RST_DATA = '0,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [1:0]       fsm_state
);

`ifdef SKID_BUFFER_EN

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             in_ready_q;
   logic             accept;
   logic             load_main;
   logic             load_skid;
   logic             main_from_skid;
   logic [WIDTH-1:0] skid_data;

   assign accept    = in_valid && in_ready_q;
   assign in_ready  = in_ready_q;
   assign out_valid = (state != ST_EMPTY);
   assign fsm_state = state;

   // State register; in_ready is precomputed from the next state so it is a flop output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != ST_TWO);
      end
   end

   // Next-state: occupancy goes up on accept, down on retire; flush empties.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (accept) state_next = ST_ONE;
            ST_ONE: begin
               if (accept && !out_ready)      state_next = ST_TWO;
               else if (!accept && out_ready) state_next = ST_EMPTY;
            end
            ST_TWO:   if (out_ready) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
         endcase
      end
   end

   // Output decode: pick which register captures data this cycle.
   always_comb begin
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (!flush) begin
         case (state)
            ST_EMPTY: load_main = accept;
            ST_ONE: begin
               load_main = accept && out_ready;
               load_skid = accept && !out_ready;
            end
            ST_TWO:   main_from_skid = out_ready;
            default: ;
         endcase
      end
   end

   // Main register: fresh beat, or the older skid beat moving up after a retire.
   always_ff @(posedge clk) begin
      if (rst)                 out_data <= RST_DATA;
      else if (load_main)      out_data <= in_data;
      else if (main_from_skid) out_data <= skid_data;
   end

   // Skid register catches the beat accepted while the output is stalled.
   always_ff @(posedge clk) begin
      if (rst)            skid_data <= RST_DATA;
      else if (load_skid) skid_data <= in_data;
   end

`else

   logic load;

   assign in_ready  = !out_valid || out_ready;
   assign load      = in_valid && in_ready && !flush;
   assign fsm_state = {1'b0, out_valid};

   // Valid flag: set on load, cleared on retire or flush.
   always_ff @(posedge clk) begin
      if (rst)            out_valid <= 1'b0;
      else if (flush)     out_valid <= 1'b0;
      else if (load)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
   end

   // Payload changes only on load so it stays stable while stalled or idle.
   always_ff @(posedge clk) begin
      if (rst)       out_data <= RST_DATA;
      else if (load) out_data <= in_data;
   end

`endif

   // Stall counter: counts held-but-not-taken cycles, saturates, clear wins.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (clr_stats)
         stall_cycles <= '0;
      else if (out_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}}))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

endmodule
